rx_queue: RTL and testbench
===========================

# rx_queue

Single-clock MAC-to-AXI receive converter for the 1G interface. It accepts the byte stream and end-of-frame status from the MAC receiver and stores each frame in an internal store-and-forward buffer. Only frames the MAC marks good are released, and they leave as an 8-bit AXI4-Stream. It sits between the MAC RX port and the interface's AXI master output, as the receive-side counterpart of the TX queue.

## Interface
- AXI_DATA_WIDTH, 8, AXI data width; only 8 is supported.
- BUF_ADDR_WIDTH, 11, log2 of buffer depth in bytes (2048 default).
- clk  in  1  sole clock, for both MAC and AXI sides.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  MAC receive byte.
- rx_data_valid  in  1  rx_data valid; high for the contiguous bytes of one frame.
- rx_good_frame  in  1  one-cycle pulse: current frame good; arrives ≥1 cycle after the last valid byte.
- rx_bad_frame  in  1  one-cycle pulse: current frame bad (CRC, length or other error).
- tdata  out  AXI_DATA_WIDTH  stream data.
- tstrb  out  AXI_DATA_WIDTH/8  equals tvalid.
- tvalid  out  1  stream valid.
- tlast  out  1  last byte of frame.
- tready  in  1  downstream ready.

## Operation
- Storage: RAM of 2^BUF_ADDR_WIDTH entries, 9 bits each ({last, byte}).
- Pointers are BUF_ADDR_WIDTH+1 bits: wr_ptr, commit_ptr, rd_ptr.
  - Buffer full when wr_ptr − rd_ptr == 2^BUF_ADDR_WIDTH.
- Write-behind hold register:
  - Each valid byte loads hold.
  - The previous hold byte is written to RAM with last=0.
- Write FSM:
  - SYNC (reset state): wait for rx_data_valid=0, then go to IDLE. This discards any frame already in progress.
  - IDLE: on rx_data_valid, load hold and go to RECV. Status pulses seen here are ignored.
  - RECV: store bytes as above.
    - If a RAM write is needed while full, go to DROP.
    - On rx_good_frame: write hold with last=1, set commit_ptr ← wr_ptr+1, go to IDLE.
    - On rx_bad_frame: set wr_ptr ← commit_ptr, discard hold, go to IDLE.
  - DROP: ignore bytes. On either status pulse, set wr_ptr ← commit_ptr and go to IDLE.
- Both status pulses in the same cycle: treat as bad.
- Status pulse in the same cycle as the first byte of the next frame:
  - Close the current frame first.
  - The new byte loads hold and the FSM stays in RECV.
- Final-byte write needs one free entry. If none is free, the frame is dropped as on overflow.
- Frames larger than 2^BUF_ADDR_WIDTH are always dropped. The free-space check uses rd_ptr, not commit_ptr.
- Read side:
  - FWFT output register fed by a 1-cycle-latency RAM read.
  - Prefetch whenever rd_ptr ≠ commit_ptr and the output register is empty or being consumed.

## Timing
- Reset values: tvalid=0, tlast=0, tdata=0, tstrb=0, all pointers 0, FSM in SYNC. Stats counters are 0.
- Latency: rx_good_frame in cycle T with an empty output gives tvalid=1 in cycle T+2.
- AXI rules:
  - While tvalid=1 and tready=0, tdata, tlast and tvalid hold.
  - A transfer occurs when tvalid&tready.
- Throughput: 1 byte/cycle with tready held high, including across back-to-back frames with no bubble.
- Pointer wrap is modulo 2^(BUF_ADDR_WIDTH+1) and needs no special cases.
- Reset mid-operation:
  - All buffered and partial frames are lost.
  - Output drops within the reset assertion.
  - After release the FSM stays in SYNC until rx_data_valid=0.

## Configuration
- RX_QUEUE_STATS_EN defined:
  - Adds outputs rx_pkt_count[31:0] and rx_drop_count[31:0].
  - rx_pkt_count increments on each committed frame.
  - rx_drop_count increments on each bad or overflow-dropped frame that had at least one byte.
  - Both counters wrap at 2^32 and reset to 0.
- RX_QUEUE_STATS_EN undefined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared package rx_queue_pkg holds:
  - write-FSM state encodings (SYNC, IDLE, RECV, DROP);
  - RAM entry width constant (9);
  - LAST bit index.
- Sub-module rx_queue_ram: simple dual-port RAM, one write port, one registered read port, parameterised by address width.

## Test plan
- Single good frame: 64 bytes 0x00..0x3F, then rx_good_frame, tready=1 → tvalid at pulse+2; 64 beats in order; tlast only on 0x3F.
- Bad frame then good frame: 20-byte frame ended by rx_bad_frame, then a 10-byte good frame → only the 10 bytes appear; drop count=1 with RX_QUEUE_STATS_EN.
- Overflow: BUF_ADDR_WIDTH=6, tready=0, 40-byte good frame then 40-byte frame → second frame dropped; with tready=1, exactly 40 bytes are output.
- Backpressure: tready toggles 1,0,0,1 repeatedly over two 15-byte frames → no byte lost or duplicated, data stable while stalled, tlast at bytes 15 and 30.
- Back-to-back: rx_good_frame coincides with the first byte of the next frame → both frames delivered intact.
- Reset mid-frame: reset_n low during byte 5 of 30, released with rx_data_valid still high → that frame is ignored entirely; the next good frame is delivered.

Source files
------------

// File: rtl/rx_queue_pkg.sv
// Shared types and constants for the MAC-to-AXI receive queue.
// Buffer entries are {last, byte}.
package rx_queue_pkg;

  typedef enum logic [1:0] {
    WR_SYNC = 2'd0,
    WR_IDLE = 2'd1,
    WR_RECV = 2'd2,
    WR_DROP = 2'd3
  } wr_state_e;

  localparam int ENTRY_W  = 9;
  localparam int LAST_BIT = 8;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic last, input logic [7:0] data);
    return {last, data};
  endfunction

endpackage

// File: rtl/rx_queue_ram.sv
// Simple dual-port buffer RAM: one write port and one registered read port.
// The read register holds its value while rd_en_i is low, so it can serve as the output stage.
module rx_queue_ram
  import rx_queue_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [ENTRY_W-1:0] rd_data_o
);

  logic [ENTRY_W-1:0] mem [2**ADDR_W];
  logic [ENTRY_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rx_queue.sv
// Store-and-forward MAC RX to 8-bit AXI4-Stream; only good frames are released, tvalid 2 cycles after rx_good_frame.
// tready low stalls the output register; optional stats counters are enabled by RX_QUEUE_STATS_EN.
module rx_queue
  import rx_queue_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 8,
  parameter int BUF_ADDR_WIDTH = 11
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_data_valid,
  input  logic                        rx_good_frame,
  input  logic                        rx_bad_frame,
  output logic [AXI_DATA_WIDTH-1:0]   tdata,
  output logic [AXI_DATA_WIDTH/8-1:0] tstrb,
  output logic                        tvalid,
  output logic                        tlast,
  input  logic                        tready
`ifdef RX_QUEUE_STATS_EN
  ,
  output logic [31:0]                 rx_pkt_count,
  output logic [31:0]                 rx_drop_count
`endif
);

  localparam int PTR_W = BUF_ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH   = {1'b1, {BUF_ADDR_WIDTH{1'b0}}};
  localparam logic [PTR_W-1:0] PTR_ONE = {{BUF_ADDR_WIDTH{1'b0}}, 1'b1};

  wr_state_e          state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [7:0]         hold_q, hold_d;
  logic               tvalid_q;

  logic               ram_we;
  logic [ENTRY_W-1:0] ram_wdata;
  logic               ram_re;
  logic [ENTRY_W-1:0] ram_rdata;
  logic               full;
  logic               frame_end;

  // Free space is measured against rd_ptr so bytes already read out are reusable mid-frame.
  assign full = ((wr_ptr_q - rd_ptr_q) == DEPTH);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    hold_d       = hold_q;
    ram_we       = 1'b0;
    ram_wdata    = make_entry(1'b0, hold_q);
    frame_end    = 1'b0;

    case (state_q)
      WR_SYNC: begin
        if (!rx_data_valid) begin
          state_d = WR_IDLE;
        end
      end

      WR_IDLE: begin
        if (rx_data_valid) begin
          hold_d  = rx_data;
          state_d = WR_RECV;
        end
      end

      WR_RECV: begin
        if (rx_bad_frame) begin
          wr_ptr_d  = commit_ptr_q;
          frame_end = 1'b1;
        end else if (rx_good_frame) begin
          if (full) begin
            wr_ptr_d = commit_ptr_q;
          end else begin
            ram_we       = 1'b1;
            ram_wdata    = make_entry(1'b1, hold_q);
            wr_ptr_d     = wr_ptr_q + PTR_ONE;
            commit_ptr_d = wr_ptr_q + PTR_ONE;
          end
          frame_end = 1'b1;
        end else if (rx_data_valid) begin
          if (full) begin
            state_d = WR_DROP;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            hold_d   = rx_data;
          end
        end

        // A byte alongside the status pulse is the first byte of the next frame.
        if (frame_end) begin
          if (rx_data_valid) begin
            hold_d = rx_data;
          end else begin
            state_d = WR_IDLE;
          end
        end
      end

      WR_DROP: begin
        if (rx_good_frame || rx_bad_frame) begin
          wr_ptr_d = commit_ptr_q;
          if (rx_data_valid) begin
            hold_d  = rx_data;
            state_d = WR_RECV;
          end else begin
            state_d = WR_IDLE;
          end
        end
      end

      default: state_d = WR_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WR_SYNC;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      hold_q       <= hold_d;
    end
  end

  // The RAM read register is the FWFT output register; a read loads it directly.
  assign ram_re = (rd_ptr_q != commit_ptr_q) && (!tvalid_q || tready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      tvalid_q <= 1'b0;
    end else begin
      if (ram_re) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      tvalid_q <= ram_re || (tvalid_q && !tready);
    end
  end

  rx_queue_ram #(
    .ADDR_W (BUF_ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (reset_n),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_ptr_q[BUF_ADDR_WIDTH-1:0]),
    .wr_data_i (ram_wdata),
    .rd_en_i   (ram_re),
    .rd_addr_i (rd_ptr_q[BUF_ADDR_WIDTH-1:0]),
    .rd_data_o (ram_rdata)
  );

  assign tdata  = ram_rdata[AXI_DATA_WIDTH-1:0];
  assign tlast  = tvalid_q && ram_rdata[LAST_BIT];
  assign tvalid = tvalid_q;
  assign tstrb  = {(AXI_DATA_WIDTH/8){tvalid_q}};

`ifdef RX_QUEUE_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] drop_cnt_q;
  logic        pkt_inc;
  logic        drop_inc;

  // Every frame reaching RECV or DROP already holds at least one byte.
  assign pkt_inc  = ram_we && ram_wdata[LAST_BIT];
  assign drop_inc = ((state_q == WR_RECV) && (rx_bad_frame || (rx_good_frame && full))) ||
                    ((state_q == WR_DROP) && (rx_bad_frame || rx_good_frame));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pkt_inc) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (drop_inc) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign rx_pkt_count  = pkt_cnt_q;
  assign rx_drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rx_queue.sv
// Directed scoreboard bench for rx_queue with a 64-byte buffer.
module tb_rx_queue;

  localparam int AW = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_valid = 1'b0;
  logic       rx_good_frame = 1'b0;
  logic       rx_bad_frame = 1'b0;
  logic       tready = 1'b0;
  logic [7:0] tdata;
  logic       tstrb;
  logic       tvalid;
  logic       tlast;
`ifdef RX_QUEUE_STATS_EN
  logic [31:0] rx_pkt_count;
  logic [31:0] rx_drop_count;
`endif

  int         checks = 0;
  int         failures = 0;
  int         beats = 0;
  logic [8:0] sb[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  always #5 clk = ~clk;

  rx_queue #(
    .AXI_DATA_WIDTH (8),
    .BUF_ADDR_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_good_frame (rx_good_frame),
    .rx_bad_frame  (rx_bad_frame),
    .tdata         (tdata),
    .tstrb         (tstrb),
    .tvalid        (tvalid),
    .tlast         (tlast),
    .tready        (tready)
`ifdef RX_QUEUE_STATS_EN
    ,
    .rx_pkt_count  (rx_pkt_count),
    .rx_drop_count (rx_drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each transfer and checks stall stability.
  always @(negedge clk) begin
    logic [8:0] exp_beat;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", 32'(tvalid), 32'd1);
        chk("stall_tdata", 32'(tdata), 32'(prev_data));
        chk("stall_tlast", 32'(tlast), 32'(prev_last));
      end
      if (tvalid && tready) begin
        beats++;
        chk("beat_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_beat = sb.pop_front();
          chk("beat_last_data", 32'({tlast, tdata}), 32'(exp_beat));
        end
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [7:0] base, input bit expect_out);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      cyc();
      b             = base + 8'(i);
      rx_data_valid = 1'b1;
      rx_data       = b;
      rx_good_frame = 1'b0;
      rx_bad_frame  = 1'b0;
      if (expect_out) sb.push_back({(i == n - 1), b});
    end
  endtask

  task automatic finish_frame(input bit good, input bit bad);
    cyc();
    rx_data_valid = 1'b0;
    rx_good_frame = good;
    rx_bad_frame  = bad;
    cyc();
    rx_good_frame = 1'b0;
    rx_bad_frame  = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    for (int c = 0; c < max_cycles && sb.size() > 0; c++) cyc();
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;

    // Reset values
    #23;
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    chk("rst_tstrb", 32'(tstrb), 32'd0);
`ifdef RX_QUEUE_STATS_EN
    chk("rst_pkt_count", rx_pkt_count, 32'd0);
    chk("rst_drop_count", rx_drop_count, 32'd0);
`endif
    cyc();
    reset_n = 1'b1;
    repeat (2) cyc();

    // Single 64-byte good frame: latency and full-rate streaming
    tready = 1'b1;
    send(64, 8'h00, 1'b1);
    cyc();
    rx_data_valid = 1'b0;
    rx_good_frame = 1'b1;
    @(negedge clk);
    chk("lat_T_tvalid", 32'(tvalid), 32'd0);
    cyc();
    rx_good_frame = 1'b0;
    @(negedge clk);
    chk("lat_T1_tvalid", 32'(tvalid), 32'd0);
    @(negedge clk);
    chk("lat_T2_tvalid", 32'(tvalid), 32'd1);
    chk("lat_T2_tdata", 32'(tdata), 32'h00);
    chk("lat_T2_tstrb", 32'(tstrb), 32'd1);
    repeat (63) @(negedge clk);
    #1;
    chk("single_no_bubble", 32'(sb.size()), 32'd0);
    repeat (3) cyc();
    chk("single_tvalid_low", 32'(tvalid), 32'd0);

    // Bad frame followed by good frame
    send(20, 8'h40, 1'b0);
    finish_frame(1'b0, 1'b1);
    send(10, 8'h80, 1'b1);
    finish_frame(1'b1, 1'b0);
    drain("bad_then_good_drain", 200);
`ifdef RX_QUEUE_STATS_EN
    chk("bad_drop_count", rx_drop_count, 32'd1);
    chk("bad_pkt_count", rx_pkt_count, 32'd2);
`endif

    // Simultaneous good and bad pulses count as bad
    send(8, 8'hA0, 1'b0);
    finish_frame(1'b1, 1'b1);
    send(5, 8'hB0, 1'b1);
    finish_frame(1'b1, 1'b0);
    drain("both_pulses_drain", 200);

    // Overflow: second 40-byte frame cannot fit while the first is stalled
    tready = 1'b0;
    send(40, 8'h00, 1'b1);
    finish_frame(1'b1, 1'b0);
    send(40, 8'h60, 1'b0);
    finish_frame(1'b1, 1'b0);
    repeat (3) cyc();
    @(negedge clk);
    chk("ovf_hold_tvalid", 32'(tvalid), 32'd1);
    chk("ovf_hold_tdata", 32'(tdata), 32'h00);
    chk("ovf_hold_tlast", 32'(tlast), 32'd0);
    b0 = beats;
    cyc();
    tready = 1'b1;
    drain("ovf_drain", 300);
    repeat (5) cyc();
    chk("ovf_beat_count", 32'(beats - b0), 32'd40);

    // Backpressure 1,0,0,1 over two 15-byte frames
    tready = 1'b0;
    send(15, 8'hC0, 1'b1);
    finish_frame(1'b1, 1'b0);
    send(15, 8'hD0, 1'b1);
    finish_frame(1'b1, 1'b0);
    b0 = beats;
    for (int c = 0; c < 600 && sb.size() > 0; c++) begin
      cyc();
      tready = ((c % 4) == 0) || ((c % 4) == 3);
    end
    chk("bp_drain", 32'(sb.size()), 32'd0);
    chk("bp_beat_count", 32'(beats - b0), 32'd30);
    cyc();
    tready = 1'b1;

    // Back-to-back: good pulse coincides with the next frame's first byte
    send(12, 8'h10, 1'b1);
    cyc();
    rx_data_valid = 1'b1;
    rx_data       = 8'h20;
    rx_good_frame = 1'b1;
    sb.push_back({1'b0, 8'h20});
    send(11, 8'h21, 1'b1);
    finish_frame(1'b1, 1'b0);
    drain("b2b_drain", 200);

    // Reset mid-frame: buffered frame and partial frame are both lost
    tready = 1'b0;
    send(6, 8'h70, 1'b0);
    finish_frame(1'b1, 1'b0);
    repeat (3) cyc();
    @(negedge clk);
    chk("pre_rst_tvalid", 32'(tvalid), 32'd1);
    b0 = beats;
    for (int i = 0; i < 30; i++) begin
      cyc();
      rx_data_valid = 1'b1;
      rx_data       = 8'hE0 + 8'(i);
      if (i == 4) begin
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid", 32'(tvalid), 32'd0);
        chk("midrst_tdata", 32'(tdata), 32'd0);
        chk("midrst_tlast", 32'(tlast), 32'd0);
      end
      if (i == 7) begin
        reset_n = 1'b1;
        tready  = 1'b1;
      end
    end
    finish_frame(1'b1, 1'b0);
    repeat (6) cyc();
    chk("midrst_no_output", 32'(beats - b0), 32'd0);
    send(7, 8'h90, 1'b1);
    finish_frame(1'b1, 1'b0);
    drain("post_rst_drain", 200);
`ifdef RX_QUEUE_STATS_EN
    chk("post_rst_pkt_count", rx_pkt_count, 32'd1);
    chk("post_rst_drop_count", rx_drop_count, 32'd0);
`endif
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
